// File: rtl/ct_decode_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | ct_pkg: word layout, bit positions and response type for the       |
// | shared CT1/CT2 decoder.                            Rev 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

package ct_pkg;

  localparam int CT_WORD_W  = 4;
  localparam int CT_IDW_MAX = 3;   // NREQ is capped at 8

  localparam int CT_C0 = 3;
  localparam int CT_C1 = 2;
  localparam int CT_K0 = 1;
  localparam int CT_K1 = 0;

  typedef logic [CT_WORD_W-1:0] ct_word_t;

  typedef struct packed {
    logic [CT_IDW_MAX-1:0] id;
    logic                  ct1;
    logic                  ct2;
  } ct_rsp_t;

endpackage

`default_nettype wire

// File: rtl/ct_decode_arbiter_if.sv
// +--------------------------------------------------------------------+
// | ct_decode_arbiter_if: request/response bundle of the decode        |
// | arbiter. Optional miss_cnt under CT_MISS_FILTER_EN.  Rev 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

interface ct_decode_arbiter_if
  import ct_pkg::*;
#(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]           req_valid;
  logic [CT_WORD_W*NREQ-1:0] req_word;
  logic [NREQ-1:0]           req_ready;
  logic                      rsp_valid;
  logic [IDW-1:0]            rsp_id;
  logic                      rsp_ct1;
  logic                      rsp_ct2;
  logic                      rsp_ready;
  logic                      busy;
`ifdef CT_MISS_FILTER_EN
  logic [7:0]                miss_cnt;

  modport master (
    output req_valid, req_word, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_ct1, rsp_ct2, busy, miss_cnt
  );
  modport slave (
    input  req_valid, req_word, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_ct1, rsp_ct2, busy, miss_cnt
  );
`else
  modport master (
    output req_valid, req_word, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_ct1, rsp_ct2, busy
  );
  modport slave (
    input  req_valid, req_word, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_ct1, rsp_ct2, busy
  );
`endif

endinterface

`default_nettype wire

// File: rtl/ct_decode_arbiter_decode.sv
// +--------------------------------------------------------------------+
// | ct_decode: combinational code-key word -> {ct1, ct2}.  Rev 1.0     |
// +--------------------------------------------------------------------+
`default_nettype none

module ct_decode
  import ct_pkg::*;
(
  input  ct_word_t word_i,
  output logic     ct1_o,
  output logic     ct2_o
);

  assign ct1_o = ~word_i[CT_C0] &  word_i[CT_C1] &  word_i[CT_K0] & ~word_i[CT_K1];
  assign ct2_o =  word_i[CT_C0] & ~word_i[CT_C1] &  word_i[CT_K0] &  word_i[CT_K1];

endmodule

`default_nettype wire

// File: rtl/ct_decode_arbiter.sv
// +--------------------------------------------------------------------+
// | ct_decode_arbiter: round-robin share of one CT decoder, 2-stage    |
// | pipeline. Option: CT_MISS_FILTER_EN drops misses.    Rev 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

module ct_decode_arbiter
  import ct_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  ct_decode_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  // Returns {found, id}; descending scan so the nearest index above ptr wins.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0] r;
    int           idx;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx]) r = {1'b1, IDW'(idx)};
    end
    return r;
  endfunction

  logic            a_valid_q, a_valid_d;
  ct_word_t        a_word_q, a_word_d;
  logic [IDW-1:0]  a_id_q, a_id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            rsp_valid_q, rsp_valid_d;
  ct_rsp_t         rsp_q, rsp_d;

  logic            dec_ct1, dec_ct2;
  logic            a_drop, b_free, a_free, b_load;
  logic [IDW:0]    pick;
  logic [NREQ-1:0] grant;

  ct_decode u_decode (
    .word_i (a_word_q),
    .ct1_o  (dec_ct1),
    .ct2_o  (dec_ct2)
  );

  always_comb begin
    a_drop = 1'b0;
`ifdef CT_MISS_FILTER_EN
    a_drop = a_valid_q & ~dec_ct1 & ~dec_ct2;
`endif
    b_free = ~rsp_valid_q | bus.rsp_ready;
    b_load = a_valid_q & b_free & ~a_drop;
    a_free = ~a_valid_q | b_free | a_drop;
    pick   = rr_pick(bus.req_valid, rr_ptr_q);

    grant       = '0;
    a_valid_d   = a_valid_q;
    a_word_d    = a_word_q;
    a_id_d      = a_id_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;

    if (a_free) begin
      a_valid_d = pick[IDW];
      if (pick[IDW]) begin
        grant[pick[IDW-1:0]] = 1'b1;
        a_word_d = bus.req_word[CT_WORD_W*int'(pick[IDW-1:0]) +: CT_WORD_W];
        a_id_d   = pick[IDW-1:0];
        rr_ptr_d = IDW'((int'(pick[IDW-1:0]) + 1) % NREQ);
      end
    end

    if (b_free) begin
      rsp_valid_d = b_load;
      if (b_load) begin
        rsp_d.id  = CT_IDW_MAX'(a_id_q);
        rsp_d.ct1 = dec_ct1;
        rsp_d.ct2 = dec_ct2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q   <= 1'b0;
      a_word_q    <= '0;
      a_id_q      <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_word_q    <= a_word_d;
      a_id_q      <= a_id_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

`ifdef CT_MISS_FILTER_EN
  logic [7:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= '0;
    end else if (a_drop && miss_cnt_q != 8'hFF) begin
      miss_cnt_q <= miss_cnt_q + 8'd1;
    end
  end

  assign bus.miss_cnt = miss_cnt_q;
`endif

  // Grant is combinational on req_valid, so mask it while reset is held.
  assign bus.req_ready = rst_n ? grant : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = IDW'(rsp_q.id);
  assign bus.rsp_ct1   = rsp_q.ct1;
  assign bus.rsp_ct2   = rsp_q.ct2;
  assign bus.busy      = a_valid_q | rsp_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ct_decode_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_ct_decode_arbiter: directed vectors for the CT decode arbiter.  |
// | Filter checks run when CT_MISS_FILTER_EN is defined.  Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ct_decode_arbiter;

  typedef struct packed {
    logic [3:0] word;
    logic       ct1;
    logic       ct2;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[16];

  ct_decode_arbiter_if #(.NREQ(4)) bus ();

  ct_decode_arbiter #(.NREQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_word  = 16'hF0B6;
    bus.rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    step();
    step();
    rst_n         = 1'b1;
    bus.req_valid = 4'b0000;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    int   nresp;
    logic [1:0] rec[4];

    for (int w = 0; w < 16; w++) tbl[w] = '{word: 4'(w), ct1: 1'b0, ct2: 1'b0};
    tbl[6]  = '{word: 4'b0110, ct1: 1'b1, ct2: 1'b0};
    tbl[11] = '{word: 4'b1011, ct1: 1'b0, ct2: 1'b1};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_word  = '0;
    bus.rsp_ready = 1'b0;
    #2;
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
    chk("rst_rsp_ct", 32'({bus.rsp_ct1, bus.rsp_ct2}), 32'h0);
    do_reset();

    // Single requester: ct1 word then ct2 word, two-edge latency.
    bus.req_word  = 16'h0006;
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("t1_lat_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t1_lat_busy", 32'(bus.busy), 32'h1);
    step();
    chk("t1_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_resp", 32'({bus.rsp_id, bus.rsp_ct1, bus.rsp_ct2}), 32'b00_1_0);
    bus.req_word  = 16'h000B;
    bus.req_valid = 4'b0001;
    #1;
    chk("t1b_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 4'b0000;
    step();
    chk("t1b_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1b_resp", 32'({bus.rsp_id, bus.rsp_ct1, bus.rsp_ct2}), 32'b00_0_1);
    step();
    chk("t1_idle_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t1_idle_busy", 32'(bus.busy), 32'h0);

    // Sweep all 16 words from requester 2, one per cycle.
    for (int j = 0; j < 18; j++) begin
      if (j < 16) begin
        bus.req_valid       = 4'b0100;
        bus.req_word[8 +: 4] = tbl[j].word;
      end else begin
        bus.req_valid = 4'b0000;
      end
      #1;
      if (j < 16) chk($sformatf("t2_ready_%0d", j), 32'(bus.req_ready), 32'h4);
      if (j >= 2) begin
        chk($sformatf("t2_valid_%0d", j - 2), 32'(bus.rsp_valid), 32'h1);
        chk($sformatf("t2_resp_%0d", j - 2),
            32'({bus.rsp_id, bus.rsp_ct1, bus.rsp_ct2}),
            32'({2'd2, tbl[j-2].ct1, tbl[j-2].ct2}));
      end
      step();
    end
    chk("t2_drained", 32'(bus.rsp_valid), 32'h0);

    // All requesters valid from rr_ptr=0: grants rotate 0,1,2,3.
    do_reset();
    bus.req_word  = 16'hF0B6;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("t3_grant_%0d", c), 32'(bus.req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        chk($sformatf("t3_resp_%0d", c),
            32'({bus.rsp_valid, bus.rsp_id, bus.rsp_ct1, bus.rsp_ct2}),
            32'({1'b1, 2'((c - 2) % 4), ((c - 2) % 4) == 0, ((c - 2) % 4) == 1}));
      end
      step();
    end

    // Backpressure: only two words fit before req_ready collapses.
    do_reset();
    bus.req_word  = 16'hF0B6;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t4_ready_%0d", c), 32'(bus.req_ready),
          (c == 0) ? 32'h1 : (c == 1) ? 32'h2 : 32'h0);
      if (c >= 2) begin
        chk($sformatf("t4_hold_%0d", c),
            32'({bus.rsp_valid, bus.rsp_id, bus.rsp_ct1, bus.rsp_ct2}),
            32'b1_00_1_0);
      end
      step();
    end
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    #1;
    chk("t4_rel0", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_ct1, bus.rsp_ct2}), 32'b1_00_1_0);
    step();
    chk("t4_rel1", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_ct1, bus.rsp_ct2}), 32'b1_01_0_1);
    step();
    chk("t4_rel_empty", 32'({bus.rsp_valid, bus.busy}), 32'h0);

    // Reset while both stages are full.
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    step();
    step();
    step();
    chk("t5_full", 32'({bus.rsp_valid, bus.busy}), 32'h3);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_ct1, bus.rsp_ct2, bus.busy}), 32'h0);
    chk("t5_rst_ready", 32'(bus.req_ready), 32'h0);
    step();
    rst_n         = 1'b1;
    bus.req_valid = 4'b1100;
    bus.rsp_ready = 1'b1;
    #1;
    chk("t5_first_grant", 32'(bus.req_ready), 32'h4);
    chk("t5_no_stale0", 32'(bus.rsp_valid), 32'h0);
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("t5_no_stale1", 32'(bus.rsp_valid), 32'h0);
    step();
    chk("t5_resp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_ct1, bus.rsp_ct2}), 32'b1_10_0_0);
    step();

`ifdef CT_MISS_FILTER_EN
    // Miss filter: only hits reach the response channel.
    do_reset();
    nresp = 0;
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = (i < 4) ? 4'b0001 : 4'b0000;
      bus.req_word  = (i == 0) ? 16'h0000 : (i == 1) ? 16'h0006 :
                      (i == 2) ? 16'h000F : 16'h000B;
      step();
      if (bus.rsp_valid) begin
        if (nresp < 4) rec[nresp] = {bus.rsp_ct1, bus.rsp_ct2};
        nresp++;
      end
    end
    chk("t6_nresp", 32'(nresp), 32'd2);
    chk("t6_first", 32'(rec[0]), 32'b10);
    chk("t6_second", 32'(rec[1]), 32'b01);
    chk("t6_miss_cnt", 32'(bus.miss_cnt), 32'd2);
    nresp = 0;
    bus.req_word  = 16'h0000;
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.rsp_valid) nresp++;
    end
    bus.req_valid = 4'b0000;
    step();
    step();
    chk("t6_miss_resp", 32'(nresp), 32'd0);
    chk("t6_miss_sat", 32'(bus.miss_cnt), 32'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
